// File: rtl/stim_seq.sv
// stim_seq: plays a window of samples from an asynchronous-read sample memory
// into a filter using a valid/ready handshake. The window can repeat, and the
// sequencer pulses done when a single pass finishes.
// Optional feature: define STIM_SEQ_FLUSH_EN to add a tail of N_TAPS zero
// samples after a single pass, which drains the filter before done.
module stim_seq #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 10,
    parameter int N_TAPS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W-1:0]        length,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [DATA_W-1:0] mem_rdata,
    output logic                     s_valid,
    output logic signed [DATA_W-1:0] s_data,
    input  logic                     s_ready,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q, len_q, cnt;
    logic [ADDR_W-1:0] base_nxt, len_nxt, cnt_nxt, addr_nxt;
    logic              last;

    // A length of 0 wraps to all ones here, so a zero length plays the
    // whole memory.
    assign last = (cnt == len_q - ONE);
    assign busy = (state != IDLE);

`ifdef STIM_SEQ_FLUSH_EN
    localparam int FW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [FW-1:0] FLAST = FW'(N_TAPS - 1);
    logic [FW-1:0] fcnt, fcnt_nxt;
`else
    // N_TAPS plays no part when there is no flush tail.
    logic unused_taps;
    assign unused_taps = ^N_TAPS;
`endif

    // Next-state and output decode. The stop check comes before the
    // handshake so a sample offered in the same cycle is never counted.
    always_comb begin
        state_nxt = state;
        base_nxt  = base_q;
        len_nxt   = len_q;
        cnt_nxt   = cnt;
        addr_nxt  = mem_addr;
        s_valid   = 1'b0;
        s_data    = '0;
        done      = 1'b0;
`ifdef STIM_SEQ_FLUSH_EN
        fcnt_nxt  = fcnt;
`endif
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    base_nxt  = base_addr;
                    len_nxt   = length;
                    addr_nxt  = base_addr;
                    cnt_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                s_valid = 1'b1;
                s_data  = mem_rdata;
                if (stop) begin
                    state_nxt = IDLE;
                end else if (s_ready) begin
                    cnt_nxt  = cnt + ONE;
                    addr_nxt = mem_addr + ONE;
                    if (last) begin
                        if (loop_en) begin
                            cnt_nxt  = '0;
                            addr_nxt = base_q;
                        end else begin
`ifdef STIM_SEQ_FLUSH_EN
                            fcnt_nxt  = '0;
                            state_nxt = FLUSH;
`else
                            state_nxt = DONE;
`endif
                        end
                    end
                end
            end
`ifdef STIM_SEQ_FLUSH_EN
            FLUSH: begin
                s_valid = 1'b1;
                if (stop) begin
                    state_nxt = IDLE;
                end else if (s_ready) begin
                    if (fcnt == FLAST) state_nxt = DONE;
                    else               fcnt_nxt  = fcnt + 1'b1;
                end
            end
`endif
            DONE: begin
                done      = !stop;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and counter registers. Reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_addr <= '0;
            cnt      <= '0;
            base_q   <= '0;
            len_q    <= '0;
`ifdef STIM_SEQ_FLUSH_EN
            fcnt     <= '0;
`endif
        end else begin
            state    <= state_nxt;
            mem_addr <= addr_nxt;
            cnt      <= cnt_nxt;
            base_q   <= base_nxt;
            len_q    <= len_nxt;
`ifdef STIM_SEQ_FLUSH_EN
            fcnt     <= fcnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_stim_seq.sv
// Testbench for stim_seq. The bench models the memory with randomized contents.
// The expected transfer stream comes from the window rules: the window
// addresses modulo 128, whole windows repeated while loop_en is high, and then
// the zero tail.
module tb_stim_seq;
    localparam int AW = 7;
    localparam int DW = 10;
`ifdef STIM_SEQ_FLUSH_EN
    localparam int TAIL = 8;
`else
    localparam int TAIL = 0;
`endif

    logic clk = 1'b0;
    logic rst, start, stop, loop_en, s_ready;
    logic [AW-1:0] base_addr, length, mem_addr;
    logic signed [DW-1:0] mem_rdata, s_data;
    logic s_valid, busy, done;

    logic signed [DW-1:0] mem [128];
    assign mem_rdata = mem[mem_addr];

    int checks = 0;
    int errors = 0;

    int obs_addr[$];
    int obs_data[$];
    int exp_addr[$];
    int exp_data[$];
    int done_cyc, idle_cyc, done_pulses, stall_bad;

    stim_seq #(.ADDR_W(AW), .DATA_W(DW), .N_TAPS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .base_addr(base_addr), .length(length), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: the stream of (address, data) transfers one run must produce.
    task automatic build_expected(input int b, input int l, input int loop_xfers);
        int len_eff, n, a;
        len_eff = (l == 0) ? 128 : l;
        n = (loop_xfers == 0) ? len_eff : ((loop_xfers / len_eff) + 1) * len_eff;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < n; i++) begin
            a = (b + (i % len_eff)) % 128;
            exp_addr.push_back(a);
            exp_data.push_back(int'(mem[a]));
        end
        for (int t = 0; t < TAIL; t++) begin
            exp_addr.push_back(-1);
            exp_data.push_back(0);
        end
    endtask

    // Returns the index of the first transfer where the observed stream differs
    // from the expected stream, or -1 when the two streams agree.
    function automatic int first_diff();
        int n;
        n = (obs_data.size() > exp_data.size()) ? obs_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            if (i >= obs_data.size() || i >= exp_data.size()) return i;
            if (exp_addr[i] != -1 && obs_addr[i] != exp_addr[i]) return i;
            if (obs_data[i] != exp_data[i]) return i;
        end
        return -1;
    endfunction

    // Drives one run and records the transfers and timing. The start cycle is
    // cycle 1. Ready mode 0 holds s_ready high, mode 1 repeats the pattern
    // 1,0,0,1, and any other mode drives random values.
    task automatic run_window(input int b, input int l, input int loop_xfers,
                              input int ready_mode, input int limit);
        int cyc, nx, prev_a, prev_d;
        logic prev_stall;
        obs_addr.delete(); obs_data.delete();
        done_cyc = 0; idle_cyc = 0; done_pulses = 0; stall_bad = 0;
        @(negedge clk);
        base_addr = AW'(b); length = AW'(l); start = 1'b1; stop = 1'b0;
        loop_en = (loop_xfers > 0); s_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; base_addr = AW'($urandom); length = AW'($urandom);
        cyc = 2; nx = 0; prev_stall = 1'b0; prev_a = 0; prev_d = 0;
        while (cyc <= limit) begin
            case (ready_mode)
                0:       s_ready = 1'b1;
                1:       s_ready = ((cyc - 2) % 4 == 0) || ((cyc - 2) % 4 == 3);
                default: s_ready = 1'($urandom_range(0, 1));
            endcase
            loop_en = (nx < loop_xfers);
            #1;
            if (prev_stall && s_valid && (int'(mem_addr) != prev_a || int'(s_data) != prev_d))
                stall_bad++;
            prev_stall = s_valid && !s_ready;
            prev_a = int'(mem_addr);
            prev_d = int'(s_data);
            if (done) begin
                done_pulses++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (s_valid && s_ready) begin
                obs_addr.push_back(int'(mem_addr));
                obs_data.push_back(int'(s_data));
                nx++;
            end
            if (done_cyc != 0 && !busy) begin
                idle_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        loop_en = 1'b0;
        s_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stop = 1'b0; loop_en = 1'b0; s_ready = 1'b1;
        base_addr = 7'd55; length = 7'd3;
        repeat (2) @(negedge clk);
        start = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", s_valid); end
        checks++; if (s_data !== '0) begin errors++; $display("FAIL reset_data got %0d want 0", s_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_pass();
        int d;
        run_window(0, 32, 0, 0, 200);
        build_expected(0, 32, 0);
        d = first_diff();
        checks++; if (d !== -1) begin errors++; $display("FAIL single_stream first diff at %0d (got %0d xfers want %0d)", d, obs_data.size(), exp_data.size()); end
        checks++; if (done_cyc !== 2 + 32 + TAIL) begin errors++; $display("FAIL single_done_cycle got %0d want %0d", done_cyc, 2 + 32 + TAIL); end
        checks++; if (idle_cyc !== 3 + 32 + TAIL) begin errors++; $display("FAIL single_idle_cycle got %0d want %0d", idle_cyc, 3 + 32 + TAIL); end
        checks++; if (done_pulses !== 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", done_pulses); end
    endtask

    task automatic test_wrap();
        int d;
        run_window(120, 16, 0, 0, 200);
        build_expected(120, 16, 0);
        d = first_diff();
        checks++; if (d !== -1) begin errors++; $display("FAIL wrap_stream first diff at %0d (got %0d xfers want %0d)", d, obs_data.size(), exp_data.size()); end
        checks++; if (done_cyc !== 2 + 16 + TAIL) begin errors++; $display("FAIL wrap_gap done cycle got %0d want %0d", done_cyc, 2 + 16 + TAIL); end
    endtask

    task automatic test_loop();
        int d, b, k;
        b = $urandom_range(0, 127);
        k = $urandom_range(5, 14);
        run_window(b, 4, k, 2, 400);
        build_expected(b, 4, k);
        d = first_diff();
        checks++; if (d !== -1) begin errors++; $display("FAIL loop_stream base %0d k %0d first diff at %0d (got %0d xfers want %0d)", b, k, d, obs_data.size(), exp_data.size()); end
        checks++; if (done_pulses !== 1 || idle_cyc == 0) begin errors++; $display("FAIL loop_done pulses %0d idle %0d want 1 and nonzero", done_pulses, idle_cyc); end
    endtask

    task automatic test_stall();
        int d, b;
        b = $urandom_range(0, 127);
        run_window(b, 12, 0, 1, 400);
        build_expected(b, 12, 0);
        d = first_diff();
        checks++; if (d !== -1) begin errors++; $display("FAIL stall_stream first diff at %0d (got %0d xfers want %0d)", d, obs_data.size(), exp_data.size()); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", stall_bad); end
    endtask

    task automatic test_random();
        int d, b, l;
        for (int it = 0; it < 4; it++) begin
            b = $urandom_range(0, 127);
            l = (it == 0) ? 0 : $urandom_range(1, 20);
            run_window(b, l, 0, 2, 2000);
            build_expected(b, l, 0);
            d = first_diff();
            checks++; if (d !== -1) begin errors++; $display("FAIL random_stream base %0d len %0d first diff at %0d (got %0d want %0d)", b, l, d, obs_data.size(), exp_data.size()); end
            checks++; if (done_pulses !== 1 || idle_cyc == 0) begin errors++; $display("FAIL random_done pulses %0d idle %0d want 1 and nonzero", done_pulses, idle_cyc); end
        end
    endtask

    task automatic test_stop();
        int seen_done;
        @(negedge clk);
        base_addr = 7'd10; length = 7'd20; start = 1'b1; stop = 1'b0; s_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1 || s_valid !== 1'b1) begin errors++; $display("FAIL stop_pre busy %b valid %b want 1 1", busy, s_valid); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL stop_idle busy %b valid %b want 0 0", busy, s_valid); end
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) seen_done++;
            @(negedge clk);
            #1;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL stop_no_done got %0d pulses want 0", seen_done); end
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_idle busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int rc, cyc;
        rc = (TAIL > 0) ? 12 : 5;
        @(negedge clk);
        base_addr = 7'd3; length = 7'd8; start = 1'b1; stop = 1'b0; s_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        while (cyc < rc) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        checks++; if (busy !== 1'b1 || s_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre busy %b valid %b want 1 1", busy, s_valid); end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || s_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl busy %b valid %b done %b want 0 0 0", busy, s_valid, done); end
        checks++; if (s_data !== '0 || mem_addr !== '0) begin errors++; $display("FAIL rstmid_data data %0d addr %0d want 0 0", s_data, mem_addr); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = DW'($urandom);
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; s_ready = 1'b1;
        base_addr = '0; length = '0;
        test_reset();
        test_single_pass();
        test_wrap();
        test_loop();
        test_stall();
        test_random();
        test_stop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stim_seq.md
STIM_SEQ -- requirements
Module: stim_seq

Interface
REQ-001 Parameter ADDR_W, default 7, sample-memory address width (128 entries).
REQ-002 Parameter DATA_W, default 10, signed sample width.
REQ-003 Parameter N_TAPS, default 8, number of zero samples emitted in the flush phase.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin a playback run; honoured only in IDLE.
REQ-007 stop  input  1  abort the current run; honoured in any non-IDLE state.
REQ-008 loop_en  input  1  1 = repeat the window indefinitely, 0 = single pass.
REQ-009 base_addr  input  ADDR_W  first sample address of the window.
REQ-010 length  input  ADDR_W  window length in samples; 0 encodes 2^ADDR_W.
REQ-011 mem_addr  output  ADDR_W  registered read address to the sample memory.
REQ-012 mem_rdata  input  DATA_W signed  asynchronous read data, mem[mem_addr].
REQ-013 s_valid  output  1  sample valid to the filter.
REQ-014 s_data  output  DATA_W signed  sample to the filter.
REQ-015 s_ready  input  1  filter accepts; transfer when s_valid & s_ready.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 done  output  1  one-cycle pulse on normal completion.

Function
REQ-018 States: IDLE, RUN, FLUSH, DONE; state register is the only control state besides counters.
REQ-019 IDLE & start & !stop: latch base_addr and length, mem_addr <= base_addr, sample count <= 0, next RUN.
REQ-020 RUN: s_valid = 1, s_data = mem_rdata (combinational pass-through, zero added latency).
REQ-021 RUN transfer: count increments; mem_addr <= mem_addr + 1 modulo 2^ADDR_W (127 wraps to 0).
REQ-022 RUN transfer of the last sample (count == latched length - 1): if loop_en then count <= 0, mem_addr <= latched base, stay RUN; else next FLUSH.
REQ-023 loop_en is sampled only on the last-sample transfer; changing it mid-window has no other effect.
REQ-024 s_valid & !s_ready: s_data, mem_addr, count, state held unchanged.
REQ-025 FLUSH: s_valid = 1, s_data = 0; after N_TAPS transfers, next DONE.
REQ-026 DONE: done = 1 for exactly one cycle, s_valid = 0, next IDLE.
REQ-027 IDLE and DONE: s_valid = 0, s_data = 0.
REQ-028 stop in RUN/FLUSH/DONE: next state IDLE, no done pulse, in-flight sample not counted as transferred.
REQ-029 start and stop both high in IDLE: stop wins; remain IDLE.
REQ-030 start outside IDLE ignored; base_addr/length changes outside IDLE ignored.

Reset
REQ-031 rst high at a clock edge: state IDLE, mem_addr 0, count 0, flush count 0, s_valid 0, s_data 0, busy 0, done 0.
REQ-032 rst overrides start, stop and any handshake in the same cycle, including mid-RUN and mid-FLUSH.

Configuration
REQ-033 Macro STIM_SEQ_FLUSH_EN defined: FLUSH state present per REQ-025.
REQ-034 STIM_SEQ_FLUSH_EN undefined: FLUSH removed; non-loop last-sample transfer goes directly to DONE; N_TAPS unused.

Verification
REQ-035 base 0, length 32, loop_en 0, s_ready 1: addresses 0..31 each presented once, 8 zero samples, done pulses on cycle 42 after start, busy low on cycle 43.
REQ-036 base 120, length 16, loop_en 0: addresses 120..127 then 0..7 presented; wrap with no gap cycle.
REQ-037 length 4, loop_en 1 for 10 transfers then 0: address sequence b, b+1, b+2, b+3 repeated; ends after the window in which loop_en was seen low; then flush and done.
REQ-038 s_ready toggling 1,0,0,1 during RUN: s_data and mem_addr stable across the stalled cycles; no sample skipped or duplicated.
REQ-039 stop asserted on the 5th RUN cycle: IDLE next cycle, s_valid 0, no done pulse; start plus stop in IDLE leaves busy 0.
REQ-040 rst asserted mid-FLUSH: all outputs at reset values next cycle; with STIM_SEQ_FLUSH_EN undefined, REQ-035 yields done on cycle 34 with no zero samples.
